main_memory_ctrl: RTL and testbench

//  Line-granular main memory model with a fixed access latency. Sits directly downstream of the

---
 rtl/main_memory_ctrl.sv | 157 +++++++++++++++
 tb/tb_main_memory_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: line-granular main memory model with a fixed access latency.
// Serves one request channel from the memory arbiter, one outstanding access at a time,
// a whole cache line per access. Array contents survive reset.
// Optional build macro: MAIN_MEMORY_STATS_EN adds mem_read_count / mem_write_count ports.
module main_memory_ctrl #(
  parameter int unsigned MEMORY_ADDRESS_SIZE = 32,
  parameter int unsigned CACHE_LINE_SIZE     = 128,
  parameter int unsigned MEMORY_DEPTH_LINES  = 4096,
  parameter int unsigned MEMORY_LATENCY      = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_enable,
  input  logic                           mem_op,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
  input  logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
  output logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
  output logic                           mem_data_ready
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [31:0]                    mem_read_count,
  output logic [31:0]                    mem_write_count
`endif
);

  // Byte offset within a line, line index width and latency counter width.
  localparam int unsigned OFS   = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned IDX_W = (MEMORY_DEPTH_LINES > 1) ? $clog2(MEMORY_DEPTH_LINES) : 1;
  localparam int unsigned CNT_W = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEMORY_LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       op_q, op_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic                       ready_q, ready_d;
  logic                       rd_en, wr_en;

  logic [CACHE_LINE_SIZE-1:0] mem_array [0:MEMORY_DEPTH_LINES-1];

  // Offset bits and upper address bits are don't-care; fold them so they read as consumed.
  logic unused_addr;
  assign unused_addr = ^mem_address;

  // State and request-latch registers; reset returns to idle with ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: accept in idle, count down in busy, hold ready until enable drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        ready_d = 1'b0;
        if (mem_enable) begin
          op_d    = mem_op;
          idx_d   = mem_address[OFS +: IDX_W];
          wdata_d = mem_data_in;
          cnt_d   = CNT_LOAD;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!mem_enable) begin
          // Requester gave up: drop the access without committing anything.
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rd_en   = ~op_q;
          wr_en   = op_q;
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        if (!mem_enable) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ready_d = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Line storage: no reset so contents persist; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  // Read data register: only a completed read updates it, writes leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_out <= '0;
    end else if (rd_en) begin
      mem_data_out <= mem_array[idx_q];
    end
  end

  assign mem_data_ready = ready_q;

`ifdef MAIN_MEMORY_STATS_EN
  // Completed-access counters; aborted accesses never reach rd_en/wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_count  <= '0;
      mem_write_count <= '0;
    end else begin
      if (rd_en) begin
        mem_read_count <= mem_read_count + 32'd1;
      end
      if (wr_en) begin
        mem_write_count <= mem_write_count + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: stimulus pushes expected responses, a monitor
// pops and checks them on every rising mem_data_ready.
module tb_main_memory_ctrl;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_enable;
  logic         mem_op;
  logic [31:0]  mem_address;
  logic [127:0] mem_data_in;
  logic [127:0] mem_data_out;
  logic         mem_data_ready;
`ifdef MAIN_MEMORY_STATS_EN
  logic [31:0]  mem_read_count;
  logic [31:0]  mem_write_count;
`endif

  main_memory_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .mem_enable     (mem_enable),
    .mem_op         (mem_op),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
`ifdef MAIN_MEMORY_STATS_EN
    .mem_read_count (mem_read_count),
    .mem_write_count(mem_write_count),
`endif
    .mem_data_ready (mem_data_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  logic prev_rdy = 1'b0;
  logic mon_en   = 1'b0;

  localparam logic [127:0] D0 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D3 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] D4 = 128'h13579BDF_2468ACE0_CAFEF00D_0BADBEEF;

  // Monitor: every rising ready must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en && mem_data_ready && !prev_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d, required no response", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (mem_data_out !== e.data) begin
          n_bad++;
          $display("FAIL resp_data: got %h required %h", mem_data_out, e.data);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL resp_latency: got cycle %0d required cycle %0d", cyc, e.cyc);
        end
      end
    end
    prev_rdy = mem_data_ready;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // One full access from a negedge; optional hold after ready and input scrambling while busy.
  task automatic access(input logic op, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp_out, input int hold, input bit scramble);
    int k;
    mem_enable  = 1'b1;
    mem_op      = op;
    mem_address = addr;
    mem_data_in = wd;
    sb.push_back('{exp_out, cyc + 1 + LAT});
    k = 0;
    while (!mem_data_ready && k < 20) begin
      @(negedge clk);
      k++;
      if (scramble && k == 2) begin
        mem_address = ~addr;
        mem_op      = ~op;
        mem_data_in = ~wd;
      end
    end
    if (!mem_data_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", k);
      sb.delete(sb.size() - 1);
    end
    repeat (hold) begin
      @(negedge clk);
      check("ready_hold", {127'd0, mem_data_ready}, 128'd1);
    end
    mem_enable = 1'b0;
    mem_op     = 1'b0;
    @(negedge clk);
    check("ready_drop", {127'd0, mem_data_ready}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100us");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    mem_enable  = 1'b0;
    mem_op      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: nothing happens.
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", {127'd0, mem_data_ready}, 128'd0);
      check("idle_dout", mem_data_out, 128'd0);
    end

    // Basic write then read back, checking latency on each.
    access(1'b1, 32'h40, D0, 128'd0, 0, 1'b0);
    access(1'b0, 32'h40, '0, D0, 0, 1'b0);

    // Offset bits ignored and index wraps modulo depth.
    access(1'b1, 32'h10, D1, D0, 0, 1'b0);
    access(1'b0, 32'h1F, '0, D1, 0, 1'b0);
    access(1'b0, 32'h10 + 32'd4096 * 32'd16, '0, D1, 0, 1'b0);

    // Aborted write must not commit or signal ready.
    access(1'b1, 32'h80, D2, D1, 0, 1'b0);
    mem_enable  = 1'b1;
    mem_op      = 1'b1;
    mem_address = 32'h80;
    mem_data_in = D3;
    repeat (3) @(negedge clk);
    mem_enable = 1'b0;
    mem_op     = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_ready", {127'd0, mem_data_ready}, 128'd0);
    end
    access(1'b0, 32'h80, '0, D2, 0, 1'b0);

    // Ready held while enable stays high; inputs changed mid-busy are ignored.
    access(1'b0, 32'h40, '0, D0, 8, 1'b1);

    // A write leaves the read register untouched.
    access(1'b1, 32'h40, D4, D0, 0, 1'b0);
    access(1'b0, 32'h10, '0, D1, 0, 1'b0);

`ifdef MAIN_MEMORY_STATS_EN
    check("read_count", {96'd0, mem_read_count}, 128'd6);
    check("write_count", {96'd0, mem_write_count}, 128'd4);
`endif

    // Reset in the middle of a read: ready and read data cleared, array kept.
    mem_enable  = 1'b1;
    mem_op      = 1'b0;
    mem_address = 32'h40;
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    mem_enable = 1'b0;
    @(negedge clk);
    check("reset_ready", {127'd0, mem_data_ready}, 128'd0);
    check("reset_dout", mem_data_out, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    access(1'b0, 32'h40, '0, D4, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
